// File: rtl/axi4s_inject_arbiter.sv
// Round-robin, packet-locked N:1 AXI4-Stream arbiter feeding a single NoC injection port.
// Arbitration happens in IDLE. In LOCKED the granted requester is passed straight through until its tlast beat fires.
module axi4s_inject_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 64,
    parameter int ID_W   = 8,
    parameter int DEST_W = 4,
    parameter int USER_W = 8
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic [N_REQ-1:0]                 s_tvalid,
    output logic [N_REQ-1:0]                 s_tready,
    input  logic [N_REQ*DATA_W-1:0]          s_tdata,
    input  logic [N_REQ*(DATA_W/8)-1:0]      s_tkeep,
    input  logic [N_REQ*(DATA_W/8)-1:0]      s_tstrb,
    input  logic [N_REQ-1:0]                 s_tlast,
    input  logic [N_REQ*ID_W-1:0]            s_tid,
    input  logic [N_REQ*DEST_W-1:0]          s_tdest,
    input  logic [N_REQ*USER_W-1:0]          s_tuser,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic [DATA_W-1:0]                m_tdata,
    output logic [DATA_W/8-1:0]              m_tkeep,
    output logic [DATA_W/8-1:0]              m_tstrb,
    output logic                             m_tlast,
    output logic [ID_W-1:0]                  m_tid,
    output logic [DEST_W-1:0]                m_tdest,
    output logic [USER_W-1:0]                m_tuser,
    output logic [$clog2(N_REQ)-1:0]         grant_id,
    output logic                             busy,
    output logic [15:0]                      pkt_count
);

    localparam int KEEP_W  = DATA_W / 8;
    localparam int GRANT_W = $clog2(N_REQ);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t             state;
    logic [GRANT_W-1:0] rr_ptr;
    logic [GRANT_W-1:0] pick;
    logic [GRANT_W-1:0] next_rr;
    logic               last_fire;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    // The loop walks from the far end back toward rr_ptr, so the last hit is the nearest requester.
    always_comb begin
        pick = rr_ptr;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            int idx;
            idx = int'(rr_ptr) + off;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (s_tvalid[idx]) pick = GRANT_W'(idx);
        end
    end

    assign next_rr = (grant_id == GRANT_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    // m_tvalid depends only on state and s_tvalid, never on m_tready.
    always_comb begin
        s_tready = '0;
        m_tvalid = 1'b0;
        if (state == LOCKED) begin
            m_tvalid           = s_tvalid[grant_id];
            s_tready[grant_id] = m_tready;
        end
    end

    // The payload is steered from the grant slice in both states; it is ignored while m_tvalid is low.
    always_comb begin
        int g;
        g       = int'(grant_id);
        m_tdata = s_tdata[g*DATA_W +: DATA_W];
        m_tkeep = s_tkeep[g*KEEP_W +: KEEP_W];
        m_tstrb = s_tstrb[g*KEEP_W +: KEEP_W];
        m_tlast = s_tlast[g];
        m_tid   = s_tid[g*ID_W +: ID_W];
        m_tdest = s_tdest[g*DEST_W +: DEST_W];
        m_tuser = s_tuser[g*USER_W +: USER_W];
    end

    assign last_fire = m_tvalid & m_tready & m_tlast;
    assign busy      = (state == LOCKED);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            pkt_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|s_tvalid) begin
                        grant_id <= pick;
                        state    <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (last_fire) begin
                        state     <= IDLE;
                        rr_ptr    <= next_rr;
                        pkt_count <= pkt_count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4s_inject_arbiter.sv
// Directed bench for axi4s_inject_arbiter with four requesters.
// Inputs change 1 ns after a rising edge, and outputs are checked 1 ns later.
module tb_axi4s_inject_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tready;
    logic [3:0]  s_tlast;
    logic [255:0] s_tdata;
    logic [31:0] s_tkeep, s_tstrb, s_tid, s_tuser;
    logic [15:0] s_tdest;
    logic        m_tvalid, m_tready, m_tlast;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep, m_tstrb, m_tid, m_tuser;
    logic [3:0]  m_tdest;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] pkt_count;

    logic [63:0] d_a    [4];
    logic [7:0]  keep_a [4];
    logic [7:0]  strb_a [4];
    logic [7:0]  id_a   [4];
    logic [3:0]  dest_a [4];
    logic [7:0]  user_a [4];

    int n_assert = 0;
    int n_fail   = 0;

    for (genvar i = 0; i < 4; i++) begin : g_pack
        assign s_tdata[i*64 +: 64] = d_a[i];
        assign s_tkeep[i*8 +: 8]   = keep_a[i];
        assign s_tstrb[i*8 +: 8]   = strb_a[i];
        assign s_tid[i*8 +: 8]     = id_a[i];
        assign s_tdest[i*4 +: 4]   = dest_a[i];
        assign s_tuser[i*8 +: 8]   = user_a[i];
    end

    always #5 CLK = ~CLK;

    axi4s_inject_arbiter dut (
        .CLK(CLK), .RST_N(RST_N),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
        .s_tstrb(s_tstrb), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .m_tstrb(m_tstrb), .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
        .grant_id(grant_id), .busy(busy), .pkt_count(pkt_count)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Each beat carries its port number and beat index so that misrouted or stale beats are visible.
    task automatic put(input int p, input logic v, input int beat, input logic last);
        s_tvalid[p] = v;
        s_tlast[p]  = last;
        d_a[p]      = {48'hD000_0000_0000, 8'(p), 8'(beat)};
        keep_a[p]   = 8'hF0 | 8'(p);
        strb_a[p]   = 8'h0F | 8'(p << 4);
        id_a[p]     = 8'h10 + 8'(p);
        dest_a[p]   = 4'(p) ^ 4'hA;
        user_a[p]   = 8'h80 | 8'(beat);
    endtask

    task automatic check_beat(input string tag, input int p, input int beat, input logic last);
        check({tag, ".m_tvalid"}, 64'(m_tvalid), 64'd1);
        check({tag, ".m_tdata"},  m_tdata, {48'hD000_0000_0000, 8'(p), 8'(beat)});
        check({tag, ".m_tlast"},  64'(m_tlast), 64'(last));
        check({tag, ".m_tdest"},  64'(m_tdest), 64'(4'(p) ^ 4'hA));
        check({tag, ".m_tkeep"},  64'(m_tkeep), 64'(8'hF0 | 8'(p)));
        check({tag, ".m_tid"},    64'(m_tid), 64'(8'h10 + 8'(p)));
        check({tag, ".m_tuser"},  64'(m_tuser), 64'(8'h80 | 8'(beat)));
        check({tag, ".grant_id"}, 64'(grant_id), 64'(p));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p;
        RST_N    = 1'b0;
        m_tready = 1'b0;
        s_tvalid = '0;
        s_tlast  = '0;
        for (int i = 0; i < 4; i++) put(i, 1'b0, 0, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        check("rst.m_tvalid",  64'(m_tvalid), 64'd0);
        check("rst.s_tready",  64'(s_tready), 64'd0);
        check("rst.busy",      64'(busy), 64'd0);
        check("rst.pkt_count", 64'(pkt_count), 64'd0);
        check("rst.grant_id",  64'(grant_id), 64'd0);

        // A single 3-beat packet from port 2: one bubble cycle, then three back-to-back beats.
        RST_N = 1'b1;
        put(2, 1'b1, 0, 1'b0);
        m_tready = 1'b1;
        #1;
        check("A.bubble.m_tvalid", 64'(m_tvalid), 64'd0);
        check("A.bubble.s_tready", 64'(s_tready), 64'd0);
        check("A.bubble.busy",     64'(busy), 64'd0);
        tick();
        check_beat("A.b0", 2, 0, 1'b0);
        check("A.b0.s_tready", 64'(s_tready), 64'h4);
        check("A.b0.busy",     64'(busy), 64'd1);
        tick(); put(2, 1'b1, 1, 1'b0); #1;
        check_beat("A.b1", 2, 1, 1'b0);
        tick(); put(2, 1'b1, 2, 1'b1); #1;
        check_beat("A.b2", 2, 2, 1'b1);
        tick(); put(2, 1'b0, 0, 1'b0); #1;
        check("A.done.busy",      64'(busy), 64'd0);
        check("A.done.m_tvalid",  64'(m_tvalid), 64'd0);
        check("A.done.pkt_count", 64'(pkt_count), 64'd1);
        check("A.done.grant_id",  64'(grant_id), 64'd2);

        // Every port sends 1-beat packets. rr_ptr is 3 after packet A, so the grant order is 3,0,1,2,3,0,1,2.
        for (int i = 0; i < 4; i++) put(i, 1'b1, 0, 1'b1);
        #1;
        for (int k = 0; k < 8; k++) begin
            p = (3 + k) % 4;
            check($sformatf("B.k%0d.idle_busy", k), 64'(busy), 64'd0);
            tick();
            check_beat($sformatf("B.k%0d", k), p, 0, 1'b1);
            check($sformatf("B.k%0d.s_tready", k), 64'(s_tready), 64'(4'b0001 << p));
            tick();
        end
        check("B.pkt_count", 64'(pkt_count), 64'd9);
        for (int i = 0; i < 4; i++) put(i, 1'b0, 0, 1'b0);

        // Port 1 holds the lock for 4 beats while port 0 keeps requesting.
        put(1, 1'b1, 0, 1'b0);
        #1;
        tick();
        check_beat("C.b0", 1, 0, 1'b0);
        put(0, 1'b1, 0, 1'b1);
        #1;
        check("C.b0.s_tready", 64'(s_tready), 64'h2);
        for (int b = 1; b < 4; b++) begin
            tick(); put(1, 1'b1, b, (b == 3)); #1;
            check_beat($sformatf("C.b%0d", b), 1, b, (b == 3));
            check($sformatf("C.b%0d.s_tready", b), 64'(s_tready), 64'h2);
        end
        tick(); put(1, 1'b0, 0, 1'b0); #1;
        check("C.gap.busy",      64'(busy), 64'd0);
        check("C.gap.s_tready",  64'(s_tready), 64'd0);
        check("C.gap.pkt_count", 64'(pkt_count), 64'd10);
        tick();
        check_beat("C.p0", 0, 0, 1'b1);
        check("C.p0.s_tready", 64'(s_tready), 64'h1);
        tick(); put(0, 1'b0, 0, 1'b0); #1;
        check("C.done.pkt_count", 64'(pkt_count), 64'd11);

        // Port 3 sends a 2-beat packet while m_tready alternates 1,0,1,0.
        put(3, 1'b1, 0, 1'b0);
        #1;
        tick();
        check_beat("D.b0", 3, 0, 1'b0);
        check("D.b0.s_tready", 64'(s_tready), 64'h8);
        tick(); put(3, 1'b1, 1, 1'b1); m_tready = 1'b0; #1;
        check_beat("D.b1_stall", 3, 1, 1'b1);
        check("D.b1_stall.s_tready",  64'(s_tready), 64'd0);
        check("D.b1_stall.pkt_count", 64'(pkt_count), 64'd11);
        tick(); m_tready = 1'b1; #1;
        check_beat("D.b1", 3, 1, 1'b1);
        check("D.b1.busy",      64'(busy), 64'd1);
        check("D.b1.pkt_count", 64'(pkt_count), 64'd11);
        tick(); put(3, 1'b0, 0, 1'b0); m_tready = 1'b0; #1;
        check("D.done.busy",      64'(busy), 64'd0);
        check("D.done.pkt_count", 64'(pkt_count), 64'd12);
        m_tready = 1'b1;

        // Port 0 stalls for two cycles mid-packet while port 2 waits its turn.
        put(0, 1'b1, 0, 1'b0);
        put(2, 1'b1, 0, 1'b0);
        #1;
        tick();
        check_beat("E.b0", 0, 0, 1'b0);
        tick(); put(0, 1'b0, 1, 1'b0); #1;
        for (int s = 0; s < 2; s++) begin
            check($sformatf("E.stall%0d.busy", s),     64'(busy), 64'd1);
            check($sformatf("E.stall%0d.m_tvalid", s), 64'(m_tvalid), 64'd0);
            check($sformatf("E.stall%0d.grant_id", s), 64'(grant_id), 64'd0);
            check($sformatf("E.stall%0d.s_tready", s), 64'(s_tready), 64'h1);
            if (s == 0) tick();
        end
        tick(); put(0, 1'b1, 1, 1'b0); #1;
        check_beat("E.b1", 0, 1, 1'b0);
        tick(); put(0, 1'b1, 2, 1'b1); #1;
        check_beat("E.b2", 0, 2, 1'b1);
        tick(); put(0, 1'b0, 0, 1'b0); #1;
        check("E.done.pkt_count", 64'(pkt_count), 64'd13);

        // Port 2 is granted next. Reset arrives during its second beat.
        tick();
        check_beat("F.b0", 2, 0, 1'b0);
        tick(); put(2, 1'b1, 1, 1'b0); RST_N = 1'b0; #1;
        check_beat("F.b1", 2, 1, 1'b0);
        tick(); put(2, 1'b0, 0, 1'b0); #1;
        check("F.rst.busy",      64'(busy), 64'd0);
        check("F.rst.m_tvalid",  64'(m_tvalid), 64'd0);
        check("F.rst.s_tready",  64'(s_tready), 64'd0);
        check("F.rst.grant_id",  64'(grant_id), 64'd0);
        check("F.rst.pkt_count", 64'(pkt_count), 64'd0);
        RST_N = 1'b1;
        put(0, 1'b1, 0, 1'b1);
        put(1, 1'b1, 0, 1'b1);
        #1;
        tick();
        check_beat("F.after", 0, 0, 1'b1);
        tick(); put(0, 1'b0, 0, 1'b0); #1;
        check("F.after.pkt_count", 64'(pkt_count), 64'd1);
        tick();
        check_beat("F.next", 1, 0, 1'b1);
        tick(); put(1, 1'b0, 0, 1'b0); #1;
        check("F.next.pkt_count", 64'(pkt_count), 64'd2);
        check("F.next.busy",      64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
